// File: rtl/wb_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_guard
// Description : Single-outstanding pipelined-Wishbone watchdog. It sits between
//               an upstream master and the WB interconnect/slave, passes the
//               bus through combinationally and counts cycles while a transfer
//               is outstanding. If the slave stays silent for TIMEOUT_CYCLES
//               active cycles, the upstream cycle is terminated with a single
//               err beat, the downstream cycle is forced low, and the faulting
//               address is captured alongside a one-cycle interrupt.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               s_*                  - upstream (slave-side) WB port
//               m_*                  - downstream (master-side) WB port
//               timeout_irq          - one-cycle pulse per timeout
//               timeout_count        - saturating timeout count since reset
//               last_timeout_adr     - s_adr at the most recent timeout
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_guard #(
    parameter int TIMEOUT_CYCLES = 1023,
    // Derived counter width; left as a parameter only for visibility.
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    // Upstream port
    input  logic [29:0] s_adr,
    input  logic [31:0] s_dat_w,
    output logic [31:0] s_dat_r,
    input  logic [3:0]  s_sel,
    input  logic        s_cyc,
    input  logic        s_stb,
    input  logic        s_we,
    output logic        s_stall,
    output logic        s_ack,
    output logic        s_err,
    // Downstream port
    output logic [29:0] m_adr,
    output logic [31:0] m_dat_w,
    output logic [3:0]  m_sel,
    output logic        m_cyc,
    output logic        m_stb,
    output logic        m_we,
    input  logic [31:0] m_dat_r,
    input  logic        m_stall,
    input  logic        m_ack,
    input  logic        m_err,
    // Status
    output logic        timeout_irq,
    output logic [15:0] timeout_count,
    output logic [29:0] last_timeout_adr
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ABORT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_abort_first;
    logic               r_irq;
    logic [15:0]        r_timeout_count;
    logic [29:0]        r_last_adr;

    logic               w_enter_abort;
    logic               w_cnt_clr;
    logic               w_cnt_inc;

    // Data/address paths never depend on state.
    assign s_dat_r          = m_dat_r;
    assign m_adr            = s_adr;
    assign m_dat_w          = s_dat_w;
    assign m_sel            = s_sel;

    assign timeout_irq      = r_irq;
    assign timeout_count    = r_timeout_count;
    assign last_timeout_adr = r_last_adr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and bus gating
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_enter_abort = 1'b0;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        m_cyc         = s_cyc;
        m_stb         = s_stb;
        m_we          = s_we;
        s_stall       = m_stall;
        s_ack         = m_ack;
        s_err         = m_err;

        case (r_state)
            S_IDLE: begin
                // A request answered in the same cycle needs no watching.
                if (s_cyc && s_stb && !m_ack && !m_err) begin
                    w_state_next = S_ACTIVE;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_ACTIVE: begin
                // A response in the terminal cycle takes priority over the timeout.
                if (m_ack || m_err) begin
                    w_state_next = S_IDLE;
                end else if (!s_cyc) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next  = S_ABORT;
                    w_enter_abort = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_ABORT: begin
                // Isolate the slave; late responses are swallowed here.
                m_cyc   = 1'b0;
                m_stb   = 1'b0;
                m_we    = 1'b0;
                s_stall = 1'b1;
                s_ack   = 1'b0;
                s_err   = r_abort_first;
                if (!s_cyc) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Abort pulse, interrupt and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abort_first   <= 1'b0;
            r_irq           <= 1'b0;
            r_timeout_count <= 16'h0000;
            r_last_adr      <= 30'd0;
        end else begin
            // Both are high only in the first ABORT cycle, so s_err and the
            // interrupt line up exactly.
            r_abort_first <= w_enter_abort;
            r_irq         <= w_enter_abort;
            if (w_enter_abort) begin
                r_last_adr <= s_adr;
                if (r_timeout_count != 16'hFFFF) begin
                    r_timeout_count <= r_timeout_count + 16'h0001;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_timeout_guard
// Description : Self-checking bench for wb_timeout_guard (TIMEOUT_CYCLES=8).
//               Directed stimulus pushes expected upstream terminations into a
//               queue; an independent monitor pops and compares whenever the
//               DUT presents s_ack or s_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timeout_guard;

    localparam int c_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] s_adr;
    logic [31:0] s_dat_w;
    logic [31:0] s_dat_r;
    logic [3:0]  s_sel;
    logic        s_cyc, s_stb, s_we;
    logic        s_stall, s_ack, s_err;
    logic [29:0] m_adr;
    logic [31:0] m_dat_w;
    logic [3:0]  m_sel;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_dat_r;
    logic        m_stall, m_ack, m_err;
    logic        timeout_irq;
    logic [15:0] timeout_count;
    logic [29:0] last_timeout_adr;

    always #5 clk = ~clk;

    wb_timeout_guard #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_adr            (s_adr),
        .s_dat_w          (s_dat_w),
        .s_dat_r          (s_dat_r),
        .s_sel            (s_sel),
        .s_cyc            (s_cyc),
        .s_stb            (s_stb),
        .s_we             (s_we),
        .s_stall          (s_stall),
        .s_ack            (s_ack),
        .s_err            (s_err),
        .m_adr            (m_adr),
        .m_dat_w          (m_dat_w),
        .m_sel            (m_sel),
        .m_cyc            (m_cyc),
        .m_stb            (m_stb),
        .m_we             (m_we),
        .m_dat_r          (m_dat_r),
        .m_stall          (m_stall),
        .m_ack            (m_ack),
        .m_err            (m_err),
        .timeout_irq      (timeout_irq),
        .timeout_count    (timeout_count),
        .last_timeout_adr (last_timeout_adr)
    );

    // Cycle index: inputs driven 1ns after posedge and outputs sampled at the
    // following negedge both belong to the same cycle number.
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [31:0] dat;
        bit          irq;
        bit          mcyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: every upstream termination must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_ack || s_err) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, expected none",
                             s_ack, s_err, cyc_n);
                end else begin
                    mon_e = q.pop_front();
                    check("resp_is_err", {31'd0, s_err},       {31'd0, mon_e.is_err});
                    check("resp_is_ack", {31'd0, s_ack},       {31'd0, !mon_e.is_err});
                    check("resp_cycle",  32'(cyc_n),           32'(mon_e.cyc));
                    check("resp_dat",    s_dat_r,              mon_e.dat);
                    check("resp_irq",    {31'd0, timeout_irq}, {31'd0, mon_e.irq});
                    check("resp_m_cyc",  {31'd0, m_cyc},       {31'd0, mon_e.mcyc});
                end
            end else if (timeout_irq) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_irq: irq=1 without s_err at cycle %0d, expected 0", cyc_n);
            end
        end
    end

    // Advance to 1ns after the posedge that starts cycle c.
    task automatic goto(input int c);
        while (cyc_n < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a single-beat request; returns the strobe cycle.
    task automatic req(input logic [29:0] adr, input logic we, input logic [31:0] dat, output int c0);
        goto(cyc_n + 1);
        c0      = cyc_n;
        s_cyc   = 1'b1;
        s_stb   = 1'b1;
        s_we    = we;
        s_adr   = adr;
        s_dat_w = dat;
        s_sel   = 4'hF;
        goto(c0 + 1);
        s_stb   = 1'b0;
    endtask

    task automatic push(input bit is_err, input int c, input logic [31:0] dat, input bit irq, input bit mcyc);
        exp_t e;
        e.is_err = is_err;
        e.cyc    = c;
        e.dat    = dat;
        e.irq    = irq;
        e.mcyc   = mcyc;
        q.push_back(e);
    endtask

    initial begin
        int c0;
        int c1;

        rst     = 1'b1;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cyc   = 1'b1;
        s_stb   = 1'b1;
        s_we    = 1'b0;
        m_dat_r = '0;
        m_stall = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;

        // Reset state: registered outputs zero, bus passes through.
        @(negedge clk);
        check("rst_irq",      {31'd0, timeout_irq}, 32'd0);
        check("rst_count",    {16'd0, timeout_count}, 32'd0);
        check("rst_last_adr", {2'd0, last_timeout_adr}, 32'd0);
        check("rst_m_cyc",    {31'd0, m_cyc}, 32'd1);
        check("rst_m_stb",    {31'd0, m_stb}, 32'd1);
        s_cyc = 1'b0;
        s_stb = 1'b0;
        goto(cyc_n + 1);
        rst = 1'b0;

        // Normal read, ack 3 cycles after the strobe.
        req(30'h100, 1'b0, 32'h0, c0);
        push(1'b0, c0 + 3, 32'hDEADBEEF, 1'b0, 1'b1);
        goto(c0 + 3);
        m_ack   = 1'b1;
        m_dat_r = 32'hDEADBEEF;
        goto(c0 + 4);
        m_ack   = 1'b0;
        m_dat_r = '0;
        s_cyc   = 1'b0;
        goto(c0 + 5);
        check("read_count", {16'd0, timeout_count}, 32'd0);

        // Write to a silent slave: err exactly 9 cycles after the strobe.
        req(30'h2A, 1'b1, 32'h55AA55AA, c0);
        push(1'b1, c0 + c_TIMEOUT + 1, 32'h0, 1'b1, 1'b0);
        goto(c0 + 10);
        check("abort_stall", {31'd0, s_stall}, 32'd1);
        check("abort_m_cyc", {31'd0, m_cyc}, 32'd0);
        s_cyc = 1'b0;
        goto(c0 + 11);
        check("to1_count",    {16'd0, timeout_count}, 32'd1);
        check("to1_last_adr", {2'd0, last_timeout_adr}, 32'h2A);

        // Ack in the 8th ACTIVE cycle beats the timeout.
        req(30'h80, 1'b0, 32'h0, c0);
        push(1'b0, c0 + 8, 32'h12345678, 1'b0, 1'b1);
        goto(c0 + 8);
        m_ack   = 1'b1;
        m_dat_r = 32'h12345678;
        goto(c0 + 9);
        m_ack   = 1'b0;
        m_dat_r = '0;
        s_cyc   = 1'b0;
        goto(c0 + 11);
        check("edge_ack_count", {16'd0, timeout_count}, 32'd1);
        check("edge_ack_adr",   {2'd0, last_timeout_adr}, 32'h2A);

        // Timeout, then a late ack while s_cyc is still high is dropped.
        req(30'h30, 1'b0, 32'h0, c0);
        push(1'b1, c0 + c_TIMEOUT + 1, 32'h0, 1'b1, 1'b0);
        goto(c0 + 10);
        m_ack   = 1'b1;
        m_dat_r = 32'h00000BAD;
        #2;
        check("late_ack_dropped", {31'd0, s_ack}, 32'd0);
        goto(c0 + 11);
        m_ack   = 1'b0;
        m_dat_r = '0;
        check("abort_hold_stall", {31'd0, s_stall}, 32'd1);
        s_cyc = 1'b0;
        goto(c0 + 12);
        check("to2_count",    {16'd0, timeout_count}, 32'd2);
        check("to2_last_adr", {2'd0, last_timeout_adr}, 32'h30);
        req(30'h4, 1'b0, 32'h0, c1);
        push(1'b0, c1 + 2, 32'hCAFEF00D, 1'b0, 1'b1);
        goto(c1 + 2);
        m_ack   = 1'b1;
        m_dat_r = 32'hCAFEF00D;
        goto(c1 + 3);
        m_ack   = 1'b0;
        m_dat_r = '0;
        s_cyc   = 1'b0;

        // Reset in the middle of a stalled ACTIVE transfer.
        m_stall = 1'b1;
        req(30'h200, 1'b0, 32'h0, c0);
        goto(c0 + 3);
        rst = 1'b1;
        #1;
        check("midrst_m_cyc",   {31'd0, m_cyc}, 32'd1);
        check("midrst_stall",   {31'd0, s_stall}, 32'd1);
        check("midrst_irq",     {31'd0, timeout_irq}, 32'd0);
        check("midrst_count",   {16'd0, timeout_count}, 32'd0);
        check("midrst_adr",     {2'd0, last_timeout_adr}, 32'd0);
        goto(c0 + 5);
        rst = 1'b0;
        goto(c0 + 20);
        check("postrst_count",  {16'd0, timeout_count}, 32'd0);
        s_cyc   = 1'b0;
        m_stall = 1'b0;

        // Saturation of the timeout counter.
        goto(cyc_n + 1);
        force dut.r_timeout_count = 16'hFFFF;
        #1;
        release dut.r_timeout_count;
        req(30'h1234, 1'b1, 32'h0, c0);
        push(1'b1, c0 + c_TIMEOUT + 1, 32'h0, 1'b1, 1'b0);
        goto(c0 + 10);
        s_cyc = 1'b0;
        goto(c0 + 11);
        check("sat_count",    {16'd0, timeout_count}, 32'h0000FFFF);
        check("sat_last_adr", {2'd0, last_timeout_adr}, 32'h1234);

        goto(cyc_n + 3);
        check("all_resp_seen", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
